// File: rtl/counter_pkg.sv
// counter_pkg: shared counter mode types for counter, timer and PWM blocks
package counter_pkg;
   typedef enum logic {MODE_WRAP, MODE_SATURATE} count_mode_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: phase counter producing a step strobe every prescale+1 enabled cycles
// Ports: clock/reset_ (sync, active-high), clear restarts phase at 0,
//        enable advances phase, prescale is divisor minus one, step is the strobe.
module tick_prescaler #(
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic                      clock,
   input  logic                      reset_,
   input  logic                      clear,
   input  logic                      enable,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      step
);
   logic [PRESCALE_WIDTH-1:0] phase_q, phase_d;
   // >= lets a shrinking prescale fire on the next enabled cycle instead of wrapping phase
   assign step = enable & (phase_q >= prescale);
   always_comb begin
      phase_d = (clear | step) ? '0 : enable ? phase_q + 1'b1 : phase_q;
   end
   always_ff @(posedge clock) begin
      if (reset_) phase_q <= '0;
      else        phase_q <= phase_d;
   end
endmodule

// File: rtl/scaled_updown_counter.sv
// scaled_updown_counter: prescaled up/down counter with load and wrap/saturate overflow
// Ports: clock/reset_ (sync, active-high), enable, up (direction), load/load_value,
//        prescale (divisor minus one); count, tick (fresh step) and carry are registered.
module scaled_updown_counter
   import counter_pkg::*;
#(
   parameter int                 WIDTH          = 16,
   parameter int                 PRESCALE_WIDTH = 4,
   parameter count_mode_t        MODE           = MODE_WRAP,
   parameter logic [WIDTH-1:0]   RESET_VALUE    = '0
) (
   input  logic                      clock,
   input  logic                      reset_,
   input  logic                      enable,
   input  logic                      up,
   input  logic                      load,
   input  logic [WIDTH-1:0]          load_value,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [WIDTH-1:0]          count,
   output logic                      tick,
   output logic                      carry
);
   logic             step, at_edge, do_step;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tick_q, tick_d, carry_q, carry_d;
   tick_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
      .clock    (clock),
      .reset_   (reset_),
      .clear    (load),
      .enable   (enable),
      .prescale (prescale),
      .step     (step)
   );
   // at_edge: this step would cross the all-ones/zero boundary
   assign at_edge = up ? &count_q : ~|count_q;
   assign do_step = step & ~load;
   always_comb begin
      count_d = load ? load_value
              : !step ? count_q
              : (MODE == MODE_SATURATE && at_edge) ? count_q
              : up ? count_q + 1'b1 : count_q - 1'b1;
      tick_d  = do_step;
      carry_d = do_step & at_edge;
   end
   always_ff @(posedge clock) begin
      if (reset_) begin
         count_q <= RESET_VALUE;
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
         carry_q <= carry_d;
      end
   end
   assign count = count_q;
   assign tick  = tick_q;
   assign carry = carry_q;
endmodule

// File: tb/tb_scaled_updown_counter.sv
// tb_scaled_updown_counter: directed checks of wrap and saturate counter instances
module tb_scaled_updown_counter;
   import counter_pkg::*;
   logic       clock = 1'b0;
   logic       reset_ = 1'b1, enable = 1'b0, up = 1'b1, load = 1'b0;
   logic [3:0] load_value = '0, prescale = '0;
   logic [3:0] count_w, count_s;
   logic       tick_w, carry_w, tick_s, carry_s;
   int         checks = 0, errors = 0;

   always #5 clock = ~clock;

   scaled_updown_counter #(.WIDTH(4), .PRESCALE_WIDTH(4), .MODE(MODE_WRAP), .RESET_VALUE(4'd0)) dut_w (
      .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load(load),
      .load_value(load_value), .prescale(prescale),
      .count(count_w), .tick(tick_w), .carry(carry_w)
   );
   scaled_updown_counter #(.WIDTH(4), .PRESCALE_WIDTH(4), .MODE(MODE_SATURATE), .RESET_VALUE(4'd0)) dut_s (
      .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load(load),
      .load_value(load_value), .prescale(prescale),
      .count(count_s), .tick(tick_s), .carry(carry_s)
   );

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [3:0] c, input logic t, input logic k);
      chk({tag, " count"}, {12'd0, count_w}, {12'd0, c});
      chk({tag, " tick"},  {15'd0, tick_w},  {15'd0, t});
      chk({tag, " carry"}, {15'd0, carry_w}, {15'd0, k});
   endtask

   task automatic chk_s(input string tag, input logic [3:0] c, input logic t, input logic k);
      chk({tag, " sat count"}, {12'd0, count_s}, {12'd0, c});
      chk({tag, " sat tick"},  {15'd0, tick_s},  {15'd0, t});
      chk({tag, " sat carry"}, {15'd0, carry_s}, {15'd0, k});
   endtask

   initial begin
      logic [3:0] cnt_seq [7];
      logic       tck_seq [7];
      logic       en_seq  [7];
      // reset state
      #1;
      cyc();
      chk_w("reset", 4'd0, 1'b0, 1'b0);
      chk_s("reset", 4'd0, 1'b0, 1'b0);
      // free run, prescale 0: 1..15, 0, 1, 2 with carry at 0
      reset_ = 1'b0; enable = 1'b1; up = 1'b1; prescale = 4'd0;
      for (int i = 1; i <= 18; i++) begin
         cyc();
         chk_w($sformatf("freerun%0d", i), 4'(i % 16), 1'b1, i == 16);
      end
      // prescale 2 with an enable gap
      reset_ = 1'b1; cyc(); reset_ = 1'b0;
      prescale = 4'd2;
      en_seq  = '{1, 1, 0, 1, 1, 1, 1};
      cnt_seq = '{0, 0, 0, 1, 1, 1, 2};
      tck_seq = '{0, 0, 0, 1, 0, 0, 1};
      for (int i = 0; i < 7; i++) begin
         enable = en_seq[i];
         cyc();
         chk_w($sformatf("gap%0d", i), cnt_seq[i], tck_seq[i], 1'b0);
      end
      // saturate: load 14, three up steps, one down step
      prescale = 4'd0; enable = 1'b1; up = 1'b1;
      load = 1'b1; load_value = 4'd14; cyc(); load = 1'b0;
      chk_s("satload", 4'd14, 1'b0, 1'b0);
      cyc(); chk_s("satup1", 4'd15, 1'b1, 1'b0);
      cyc(); chk_s("satup2", 4'd15, 1'b1, 1'b1);
      cyc(); chk_s("satup3", 4'd15, 1'b1, 1'b1);
      up = 1'b0;
      cyc(); chk_s("satdn", 4'd14, 1'b1, 1'b0);
      // saturate at zero going down
      load = 1'b1; load_value = 4'd0; cyc(); load = 1'b0;
      cyc(); chk_s("satlow", 4'd0, 1'b1, 1'b1);
      // down wrap then direction change
      load = 1'b1; load_value = 4'd1; cyc(); load = 1'b0;
      chk_w("wrapload", 4'd1, 1'b0, 1'b0);
      up = 1'b0;
      cyc(); chk_w("dn1", 4'd0, 1'b1, 1'b0);
      cyc(); chk_w("dn2", 4'd15, 1'b1, 1'b1);
      up = 1'b1;
      cyc(); chk_w("up1", 4'd0, 1'b1, 1'b1);
      cyc(); chk_w("up2", 4'd1, 1'b1, 1'b0);
      // load wins over a concurrent step
      load = 1'b1; load_value = 4'd9; cyc(); load = 1'b0;
      chk_w("collide", 4'd9, 1'b0, 1'b0);
      cyc(); chk_w("afterload", 4'd10, 1'b1, 1'b0);
      // reset mid-count, also clears a saturation hold
      reset_ = 1'b1; cyc(); reset_ = 1'b0;
      chk_w("midreset", 4'd0, 1'b0, 1'b0);
      chk_s("midreset", 4'd0, 1'b0, 1'b0);
      enable = 1'b0;
      cyc(); chk_w("idle1", 4'd0, 1'b0, 1'b0);
      cyc(); chk_w("idle2", 4'd0, 1'b0, 1'b0);
      // prescale shrink from 7 at phase 5 down to 2
      prescale = 4'd7; enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_w($sformatf("slow%0d", i), 4'd0, 1'b0, 1'b0);
      end
      prescale = 4'd2;
      cyc(); chk_w("shrink", 4'd1, 1'b1, 1'b0);
      cyc(); chk_w("shrink+1", 4'd1, 1'b0, 1'b0);
      cyc(); chk_w("shrink+2", 4'd1, 1'b0, 1'b0);
      cyc(); chk_w("shrink+3", 4'd2, 1'b1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
